// File: rtl/apb_req_arbiter.sv
// Round-robin two-client front end for the APB bridge user port. It runs one transaction at a time.
// Define APB_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT cycles with no pready.
module apb_req_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ack,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  transfer,
    output logic                  READ_WRITE,
    output logic [ADDR_W-1:0]     apb_read_paddr,
    output logic [ADDR_W-1:0]     apb_write_paddr,
    output logic [DATA_W-1:0]     apb_write_data,
    input  logic [DATA_W-1:0]     apb_read_data_out,
    input  logic                  pready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_reg;
    logic              grant_reg;
    logic              last_reg;
    logic              timeout_hit;

    logic              win;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the client that did not win last time goes next.
    always_comb begin
        win = req_valid[1];
        if (&req_valid) begin
            win = ~last_reg;
        end
        sel_write = win ? req_write[1] : req_write[0];
        sel_addr  = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_wdata = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_reg;

    // Held at zero in IDLE, so every BUSY stretch starts counting from zero.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            cnt_reg <= '0;
        end else if (state_reg == BUSY && !pready) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // pready in the final allowed cycle takes priority over the abort.
    assign timeout_hit = !pready && (cnt_reg == CNT_W'(TIMEOUT - 1));
`else
    // No watchdog in this build; TIMEOUT only feeds a constant-false term.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg       <= IDLE;
            grant_reg       <= 1'b0;
            last_reg        <= 1'b1;
            req_ack         <= 2'b00;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            transfer        <= 1'b0;
            READ_WRITE      <= 1'b0;
            apb_read_paddr  <= '0;
            apb_write_paddr <= '0;
            apb_write_data  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ack <= 2'b00;
                    rsp_err <= 1'b0;
                    if (|req_valid) begin
                        state_reg  <= BUSY;
                        grant_reg  <= win;
                        last_reg   <= win;
                        transfer   <= 1'b1;
                        READ_WRITE <= ~sel_write;
                        if (sel_write) begin
                            apb_write_paddr <= sel_addr;
                            apb_write_data  <= sel_wdata;
                            apb_read_paddr  <= '0;
                        end else begin
                            apb_read_paddr  <= sel_addr;
                            apb_write_paddr <= '0;
                            apb_write_data  <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (pready || timeout_hit) begin
                        state_reg       <= DONE;
                        transfer        <= 1'b0;
                        READ_WRITE      <= 1'b0;
                        apb_read_paddr  <= '0;
                        apb_write_paddr <= '0;
                        apb_write_data  <= '0;
                        req_ack         <= {grant_reg, ~grant_reg};
                        rsp_err         <= ~pready;
                        // READ_WRITE still holds this transaction's direction here.
                        if (pready && READ_WRITE) begin
                            rsp_rdata <= apb_read_data_out;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    req_ack   <= 2'b00;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
